pixel_deser: RTL and testbench
==============================

PIXEL_DESER -- requirements
Module: pixel_deser

Interface
REQ-001 SHALL have parameter N, default 24, parallel word width in bits (one RGB pixel).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_N  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sIn  input  1  serial data bit, MSB first.
REQ-005 SHALL have port sEn_N  input  1  active-high bit strobe; sIn is sampled only when high.
REQ-006 SHALL have port sync  input  1  word-start marker, qualified by sEn_N; marks the current bit as the MSB.
REQ-007 SHALL have port clr  input  1  synchronous clear of the sticky error flags.
REQ-008 SHALL have port q  output  N  assembled parallel word, held until accepted.
REQ-009 SHALL have port qValid  output  1  q holds an unconsumed word.
REQ-010 SHALL have port qReady  input  1  consumer accepts q when qValid&&qReady.
REQ-011 SHALL have port busy  output  1  a partial word is in progress.
REQ-012 SHALL have port overrun  output  1  sticky; a completed word was dropped because the buffer was full.
REQ-013 SHALL have port parity_err  output  1  sticky parity-mismatch flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, PARITY (PARITY exists only when the macro is enabled).
REQ-015 SHALL advance only on cycles with sEn_N=1; all other cycles hold state, counter and shift register.
REQ-016 SHALL, in IDLE, discard strobed bits with sync=0; a strobed bit with sync=1 loads bit 1 of the word and enters SHIFT with count=1.
REQ-017 SHALL shift each strobed bit in as sh <= {sh[N-2:0], sIn} and increment a ceil(log2(N+1))-bit counter.
REQ-018 SHALL treat the strobed bit with count==N-1 as the LSB, completing the word; the next state is PARITY if enabled, else IDLE.
REQ-019 SHALL assert qValid and update q on the clock edge after the completing bit (latency 1 cycle from the last sampled bit).
REQ-020 SHALL deassert qValid on the edge following qValid&&qReady, unless a new word completes on that same cycle, in which case q takes the new word and qValid stays 1.
REQ-021 SHALL, when a word completes while qValid=1 and qReady=0, drop the new word, keep q unchanged, and set overrun.
REQ-022 SHALL, when sync=1 arrives with a strobe in SHIFT or PARITY, discard the partial word and restart at count=1 with that bit; no flag is set.
REQ-023 SHALL drive busy=1 exactly when the state is not IDLE.
REQ-024 SHALL clear overrun and parity_err on clr=1; if clr and a set condition occur in the same cycle, set wins.

Reset
REQ-025 SHALL, on reset_N=1, immediately force state=IDLE, count=0, shift register=0, q=0, qValid=0, busy=0, overrun=0, parity_err=0.
REQ-026 SHALL discard a word that is partially received when reset occurs; after release, reception resumes only at the next sync.

Configuration
REQ-027 SHALL honour the macro PIXEL_DESER_PARITY_EN: when it is defined, one even-parity bit follows the LSB and is checked in the PARITY state.
REQ-028 SHALL, with the macro defined, deliver the word per REQ-019 through REQ-021 on a parity match, measured from the parity bit; on a mismatch it drops the word and sets parity_err.
REQ-029 SHALL, with the macro undefined, omit the PARITY state and tie parity_err to 0.

Structure
REQ-030 SHALL place the state enum typedef and the localparam PIX_W=24 in the shared package pixel_pkg.
REQ-031 SHALL isolate the shift register and bit counter in one sub-module, sipo_core; the FSM, output buffer and flags remain in pixel_deser.

Verification
REQ-032 SHALL test: sync on the first of 24 strobed bits carrying 0xA5C3F0, qReady=1 -> qValid=1 one cycle after the last bit with q=0xA5C3F0, then qValid=0 the next cycle.
REQ-033 SHALL test: word 0x123456 is held with qReady=0 and a second word 0xFFFFFF completes -> q stays 0x123456 and overrun=1; clr -> overrun=0.
REQ-034 SHALL test: sync at bit 10 of a word, then 24 bits carrying 0x00FF00 -> exactly one word, 0x00FF00, is delivered.
REQ-035 SHALL test: reset_N pulsed after 12 bits, then a full word 0x0F0F0F -> q=0x0F0F0F and no spurious qValid before it.
REQ-036 SHALL test: gapped strobes (sEn_N toggling every other cycle) carrying 0xC0FFEE -> q=0xC0FFEE.
REQ-037 SHALL test, with PIXEL_DESER_PARITY_EN defined: 0x000001 followed by parity bit 0 -> word dropped and parity_err=1; parity bit 1 -> word delivered.

Source files
------------

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared types for pixel_deser (PARITY state only with PIXEL_DESER_PARITY_EN)
package pixel_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef PIXEL_DESER_PARITY_EN
        , PARITY
`endif
    } state_e;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_SHIFT,
        OP_SHIFT_END,
        OP_END
    } sipo_op_e;

endpackage

// File: rtl/pixel_deser_if.sv
// rtl/pixel_deser_if.sv - serial-in / parallel-out bus of pixel_deser
interface pixel_deser_if
    import pixel_pkg::*;
#(
    parameter int N = PIX_W
) ();
    logic         sIn;
    logic         sEn_N;
    logic         sync;
    logic         clr;
    logic [N-1:0] q;
    logic         qValid;
    logic         qReady;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    modport master (
        output sIn, sEn_N, sync, clr, qReady,
        input  q, qValid, busy, overrun, parity_err
    );

    modport slave (
        input  sIn, sEn_N, sync, clr, qReady,
        output q, qValid, busy, overrun, parity_err
    );
endinterface

// File: rtl/sipo_core.sv
// rtl/sipo_core.sv - shift register and bit counter (register widened by PIXEL_DESER_PARITY_EN)
module sipo_core
    import pixel_pkg::*;
#(
    parameter int N  = PIX_W,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset_N,
    input  sipo_op_e      op,
    input  logic          bit_in,
    output logic [N-1:0]  word,
    output logic [CW-1:0] count
);
    // Without parity the LSB is delivered straight from bit_in, so only N-1 bits need storing.
`ifdef PIXEL_DESER_PARITY_EN
    localparam int SH_W = N;
`else
    localparam int SH_W = N - 1;
`endif

    logic [SH_W-1:0] sh;

    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) begin
            sh    <= '0;
            count <= '0;
        end else begin
            case (op)
                OP_LOAD: begin
                    sh    <= SH_W'(bit_in);
                    count <= CW'(1);
                end
                OP_SHIFT: begin
                    sh    <= {sh[SH_W-2:0], bit_in};
                    count <= count + CW'(1);
                end
                OP_SHIFT_END: begin
                    sh    <= {sh[SH_W-2:0], bit_in};
                    count <= '0;
                end
                OP_END:  count <= '0;
                default: ;
            endcase
        end
    end

`ifdef PIXEL_DESER_PARITY_EN
    assign word = sh;
`else
    assign word = {sh, bit_in};
`endif

endmodule

// File: rtl/pixel_deser.sv
// rtl/pixel_deser.sv - serial pixel deserializer; even-parity check under PIXEL_DESER_PARITY_EN
module pixel_deser
    import pixel_pkg::*;
#(
    parameter int N = PIX_W
) (
    input  logic          clk,
    input  logic          reset_N,
    pixel_deser_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    state_e        state;
    state_e        next_state;
    sipo_op_e      op;
    logic [N-1:0]  word;
    logic [CW-1:0] count;
    logic          word_done;
    logic          overrun_set;
    logic [N-1:0]  q_r;
    logic          q_valid_r;
    logic          overrun_r;

    sipo_core #(.N(N), .CW(CW)) u_core (
        .clk     (clk),
        .reset_N (reset_N),
        .op      (op),
        .bit_in  (bus.sIn),
        .word    (word),
        .count   (count)
    );

    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) state <= IDLE;
        else         state <= next_state;
    end

`ifdef PIXEL_DESER_PARITY_EN
    logic parity_bad;
    logic parity_err_r;
`endif

    always_comb begin
        next_state = state;
        op         = OP_HOLD;
        word_done  = 1'b0;
`ifdef PIXEL_DESER_PARITY_EN
        parity_bad = 1'b0;
`endif
        if (bus.sEn_N) begin
            case (state)
                IDLE: begin
                    if (bus.sync) begin
                        op         = OP_LOAD;
                        next_state = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.sync) begin
                        op = OP_LOAD;
                    end else if (count == CW'(N - 1)) begin
`ifdef PIXEL_DESER_PARITY_EN
                        op         = OP_SHIFT;
                        next_state = PARITY;
`else
                        op         = OP_SHIFT_END;
                        next_state = IDLE;
                        word_done  = 1'b1;
`endif
                    end else begin
                        op = OP_SHIFT;
                    end
                end
`ifdef PIXEL_DESER_PARITY_EN
                PARITY: begin
                    if (bus.sync) begin
                        op         = OP_LOAD;
                        next_state = SHIFT;
                    end else begin
                        op         = OP_END;
                        next_state = IDLE;
                        // Even parity: word bits plus parity bit must XOR to zero.
                        if (^{word, bus.sIn}) parity_bad = 1'b1;
                        else                  word_done  = 1'b1;
                    end
                end
`endif
                default: next_state = IDLE;
            endcase
        end
    end

    assign overrun_set = word_done && q_valid_r && !bus.qReady;

    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) begin
            q_r       <= '0;
            q_valid_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (word_done && (!q_valid_r || bus.qReady)) begin
                q_r       <= word;
                q_valid_r <= 1'b1;
            end else if (q_valid_r && bus.qReady) begin
                q_valid_r <= 1'b0;
            end
            overrun_r <= overrun_set | (overrun_r & ~bus.clr);
        end
    end

`ifdef PIXEL_DESER_PARITY_EN
    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) parity_err_r <= 1'b0;
        else         parity_err_r <= parity_bad | (parity_err_r & ~bus.clr);
    end
    assign bus.parity_err = parity_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.q       = q_r;
    assign bus.qValid  = q_valid_r;
    assign bus.overrun = overrun_r;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_pixel_deser.sv
// tb/tb_pixel_deser.sv - directed bench for pixel_deser (parity test under PIXEL_DESER_PARITY_EN)
module tb_pixel_deser;
    import pixel_pkg::*;

    logic        clk = 1'b0;
    logic        reset_N;
    int          vectors = 0;
    int          miscompares = 0;
    int          valid_seen = 0;
    logic [23:0] last_q = '0;
    bit          early;

    pixel_deser_if #(.N(24)) bus ();

    pixel_deser #(.N(24)) dut (
        .clk     (clk),
        .reset_N (reset_N),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.qValid) begin
            valid_seen++;
            last_q = bus.q;
        end
    endtask

    task automatic send_bit(input logic b, input logic s, input logic en);
        @(negedge clk);
        bus.sIn   = b;
        bus.sync  = s;
        bus.sEn_N = en;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sIn   = 1'b0;
            bus.sync  = 1'b0;
            bus.sEn_N = 1'b0;
            tick();
        end
    endtask

    task automatic send_head(input logic [23:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[23-i], i == 0, 1'b1);
    endtask

    task automatic send_word(input logic [23:0] w, output bit early_valid);
        early_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            send_bit(w[23-i], i == 0, 1'b1);
`ifdef PIXEL_DESER_PARITY_EN
            if (bus.qValid) early_valid = 1'b1;
`else
            if (i < 23 && bus.qValid) early_valid = 1'b1;
`endif
        end
`ifdef PIXEL_DESER_PARITY_EN
        send_bit(^w, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_reset();
        bus.sIn = 0; bus.sEn_N = 0; bus.sync = 0; bus.clr = 0; bus.qReady = 0;
        reset_N = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_N = 1'b1;
        #1;
        vectors++; if (bus.q !== 24'h0)      begin miscompares++; $display("FAIL reset_q: got %h want %h", bus.q, 24'h0); end
        vectors++; if (bus.qValid !== 1'b0)  begin miscompares++; $display("FAIL reset_qValid: got %b want 0", bus.qValid); end
        vectors++; if (bus.busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        vectors++; if (bus.parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_parity_err: got %b want 0", bus.parity_err); end
        @(negedge clk);
        reset_N = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        bus.qReady = 1'b1;
        send_word(24'hA5C3F0, early);
        vectors++; if (early !== 1'b0)      begin miscompares++; $display("FAIL basic_early: got %b want 0", early); end
        vectors++; if (bus.qValid !== 1'b1) begin miscompares++; $display("FAIL basic_qValid: got %b want 1", bus.qValid); end
        vectors++; if (bus.q !== 24'hA5C3F0) begin miscompares++; $display("FAIL basic_q: got %h want a5c3f0", bus.q); end
        vectors++; if (bus.busy !== 1'b0)   begin miscompares++; $display("FAIL basic_busy: got %b want 0", bus.busy); end
        idle(1);
        vectors++; if (bus.qValid !== 1'b0) begin miscompares++; $display("FAIL basic_consumed: got %b want 0", bus.qValid); end
    endtask

    task automatic test_overrun();
        bus.qReady = 1'b0;
        send_word(24'h123456, early);
        vectors++; if (bus.q !== 24'h123456) begin miscompares++; $display("FAIL ovr_first_q: got %h want 123456", bus.q); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_first_flag: got %b want 0", bus.overrun); end
        send_word(24'hFFFFFF, early);
        vectors++; if (bus.q !== 24'h123456) begin miscompares++; $display("FAIL ovr_held_q: got %h want 123456", bus.q); end
        vectors++; if (bus.qValid !== 1'b1)  begin miscompares++; $display("FAIL ovr_held_valid: got %b want 1", bus.qValid); end
        vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
        bus.clr = 1'b1;
        idle(1);
        bus.clr = 1'b0;
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clr: got %b want 0", bus.overrun); end
        bus.clr = 1'b1;
        send_word(24'h00000F, early);
        vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set_wins: got %b want 1", bus.overrun); end
        bus.clr = 1'b0;
        bus.qReady = 1'b1;
        idle(1);
        vectors++; if (bus.qValid !== 1'b0)  begin miscompares++; $display("FAIL ovr_drain: got %b want 0", bus.qValid); end
        vectors++; if (bus.q !== 24'h123456) begin miscompares++; $display("FAIL ovr_drain_q: got %h want 123456", bus.q); end
        bus.clr = 1'b1;
        idle(1);
        bus.clr = 1'b0;
    endtask

    task automatic test_resync();
        bus.qReady = 1'b1;
        valid_seen = 0;
        send_head(24'hABCDEF, 10);
        send_word(24'h00FF00, early);
        idle(2);
        vectors++; if (valid_seen !== 1)      begin miscompares++; $display("FAIL resync_count: got %0d want 1", valid_seen); end
        vectors++; if (last_q !== 24'h00FF00) begin miscompares++; $display("FAIL resync_q: got %h want 00ff00", last_q); end
        vectors++; if (bus.overrun !== 1'b0)  begin miscompares++; $display("FAIL resync_flag: got %b want 0", bus.overrun); end
    endtask

    task automatic test_reset_midword();
        bus.qReady = 1'b1;
        send_head(24'hFFFFFF, 12);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
        @(negedge clk);
        bus.sEn_N = 1'b0;
        reset_N = 1'b1;
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy_async: got %b want 0", bus.busy); end
        @(negedge clk);
        reset_N = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 13; i++) send_bit(1'b1, 1'b0, 1'b1);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_nosync: got %b want 0", bus.busy); end
        send_word(24'h0F0F0F, early);
        vectors++; if (early !== 1'b0)       begin miscompares++; $display("FAIL midrst_early: got %b want 0", early); end
        vectors++; if (bus.qValid !== 1'b1)  begin miscompares++; $display("FAIL midrst_valid: got %b want 1", bus.qValid); end
        vectors++; if (bus.q !== 24'h0F0F0F) begin miscompares++; $display("FAIL midrst_q: got %h want 0f0f0f", bus.q); end
        vectors++; if (valid_seen !== 1)     begin miscompares++; $display("FAIL midrst_count: got %0d want 1", valid_seen); end
        idle(1);
    endtask

    task automatic test_gapped();
        logic [23:0] w;
        w = 24'hC0FFEE;
        bus.qReady = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 24; i++) begin
            send_bit(w[23-i], i == 0, 1'b1);
`ifdef PIXEL_DESER_PARITY_EN
            send_bit(~w[23-i], 1'b1, 1'b0);
`else
            if (i < 23) send_bit(~w[23-i], 1'b1, 1'b0);
`endif
        end
`ifdef PIXEL_DESER_PARITY_EN
        send_bit(^w, 1'b0, 1'b1);
`endif
        vectors++; if (bus.qValid !== 1'b1)  begin miscompares++; $display("FAIL gap_valid: got %b want 1", bus.qValid); end
        vectors++; if (bus.q !== 24'hC0FFEE) begin miscompares++; $display("FAIL gap_q: got %h want c0ffee", bus.q); end
        vectors++; if (valid_seen !== 1)     begin miscompares++; $display("FAIL gap_count: got %0d want 1", valid_seen); end
        idle(1);
    endtask

`ifdef PIXEL_DESER_PARITY_EN
    task automatic test_parity();
        bus.qReady = 1'b1;
        valid_seen = 0;
        send_head(24'h000001, 24);
        vectors++; if (bus.qValid !== 1'b0) begin miscompares++; $display("FAIL par_wait: got %b want 0", bus.qValid); end
        send_bit(1'b0, 1'b0, 1'b1);
        vectors++; if (bus.parity_err !== 1'b1) begin miscompares++; $display("FAIL par_err_set: got %b want 1", bus.parity_err); end
        vectors++; if (bus.busy !== 1'b0)       begin miscompares++; $display("FAIL par_busy: got %b want 0", bus.busy); end
        idle(1);
        vectors++; if (valid_seen !== 0)        begin miscompares++; $display("FAIL par_dropped: got %0d want 0", valid_seen); end
        send_head(24'h000001, 24);
        send_bit(1'b1, 1'b0, 1'b1);
        vectors++; if (bus.qValid !== 1'b1)     begin miscompares++; $display("FAIL par_ok_valid: got %b want 1", bus.qValid); end
        vectors++; if (bus.q !== 24'h000001)    begin miscompares++; $display("FAIL par_ok_q: got %h want 000001", bus.q); end
        vectors++; if (bus.parity_err !== 1'b1) begin miscompares++; $display("FAIL par_sticky: got %b want 1", bus.parity_err); end
        bus.clr = 1'b1;
        idle(1);
        bus.clr = 1'b0;
        vectors++; if (bus.parity_err !== 1'b0) begin miscompares++; $display("FAIL par_clr: got %b want 0", bus.parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_resync();
        test_reset_midword();
        test_gapped();
`ifdef PIXEL_DESER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
